// File: rtl/keypad_scan_if.sv
// Keypad row/column wiring plus the decoded key outputs of keypad_scan.
// master: the scanner side; slave: keypad matrix and key consumer side.
interface keypad_scan_if;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] hexs;

    modport master (
        output row,
        output key_code,
        output key_valid,
        output key_held,
        output hexs,
        input  col
    );

    modport slave (
        input  row,
        input  key_code,
        input  key_valid,
        input  key_held,
        input  hexs,
        output col
    );
endinterface

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: row drive, column sync, press/release debounce,
// and a four-deep history of accepted key codes.
module keypad_scan #(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic          clk,
    input  logic          rst,
    keypad_scan_if.master kp
);
    localparam int unsigned    DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]     DB_N     = 4'(DEBOUNCE_SCANS);

    localparam logic [1:0] S_SCAN     = 2'd0;
    localparam logic [1:0] S_DEBOUNCE = 2'd1;
    localparam logic [1:0] S_HELD     = 2'd2;
    localparam logic [1:0] S_RELEASE  = 2'd3;

    logic [3:0]       r_col_m;
    logic [3:0]       r_col_s;
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_state;
    logic [1:0]       r_row_idx;
    logic [3:0]       r_cnt;
    logic [3:0]       r_pat;
    logic [1:0]       r_col_idx;
    logic [3:0]       r_key_code;
    logic             r_key_valid;
    logic             r_key_held;
    logic [15:0]      r_hexs;

    logic             w_tick;
    logic             w_all_high;
    logic [1:0]       w_low_idx;

    assign w_tick     = (r_div == DIV_LAST);
    assign w_all_high = (r_col_s == 4'hF);

    // Last assignment wins, so the lowest-numbered low column is selected.
    always_comb begin
        w_low_idx = 2'd0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!r_col_s[3 - i]) w_low_idx = 2'(3 - i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col_m     <= '1;
            r_col_s     <= '1;
            r_div       <= '0;
            r_state     <= S_SCAN;
            r_row_idx   <= '0;
            r_cnt       <= '0;
            r_pat       <= '1;
            r_col_idx   <= '0;
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
            r_hexs      <= '0;
        end else begin
            r_col_m     <= kp.col;
            r_col_s     <= r_col_m;
            r_div       <= w_tick ? '0 : r_div + 1'b1;
            r_key_valid <= 1'b0;

            case (r_state)
                S_SCAN: begin
                    if (w_tick) begin
                        if (w_all_high) begin
                            r_row_idx <= r_row_idx + 2'd1;
                        end else begin
                            r_pat     <= r_col_s;
                            r_col_idx <= w_low_idx;
                            r_cnt     <= 4'd1;
                            r_state   <= S_DEBOUNCE;
                        end
                    end
                end
                // Acceptance is checked before sampling so it lands on the edge
                // after the count reaches its target, independent of the tick.
                S_DEBOUNCE: begin
                    if (r_cnt >= DB_N) begin
                        r_key_code  <= {r_row_idx, r_col_idx};
                        r_key_valid <= 1'b1;
                        r_key_held  <= 1'b1;
                        r_hexs      <= {r_hexs[11:0], r_row_idx, r_col_idx};
                        r_cnt       <= '0;
                        r_state     <= S_HELD;
                    end else if (w_tick) begin
                        if (r_col_s == r_pat) begin
                            r_cnt <= r_cnt + 4'd1;
                        end else begin
                            r_cnt     <= '0;
                            r_row_idx <= r_row_idx + 2'd1;
                            r_state   <= S_SCAN;
                        end
                    end
                end
                S_HELD: begin
                    if (w_tick && w_all_high) begin
                        r_cnt   <= 4'd1;
                        r_state <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (r_cnt >= DB_N) begin
                        r_key_held <= 1'b0;
                        r_row_idx  <= r_row_idx + 2'd1;
                        r_cnt      <= '0;
                        r_state    <= S_SCAN;
                    end else if (w_tick) begin
                        if (w_all_high) begin
                            r_cnt <= r_cnt + 4'd1;
                        end else begin
                            r_cnt   <= '0;
                            r_state <= S_HELD;
                        end
                    end
                end
                default: r_state <= S_SCAN;
            endcase
        end
    end

    assign kp.row       = ~(4'b0001 << r_row_idx);
    assign kp.key_code  = r_key_code;
    assign kp.key_valid = r_key_valid;
    assign kp.key_held  = r_key_held;
    assign kp.hexs      = r_hexs;
endmodule
